// File: rtl/behav_and_gate.sv
// Registered bitwise AND with a valid/ready handshake and a one-deep output stage.
// Define BEHAV_AND_GATE_STATS_EN to include the saturating accepted-transaction counter.
module behav_and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             s_all,
  output logic             s_any,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_count
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("behav_and_gate: WIDTH must be in 1..64");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
      $error("behav_and_gate: CNT_W must be in 2..32");
    end
  endgenerate

  logic accept;

  // The stage frees up in the same cycle its result is consumed, so a full
  // pipe sustains one result per clock without a bubble.
  assign in_ready = (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: s is cleared too, not just out_valid, so the reduction outputs
      // read 0 during reset and no stale pending result survives it.
      s         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      s         <= a & b;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign s_all = &s;
  assign s_any = |s;

`ifdef BEHAV_AND_GATE_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign txn_count = cnt_q;
`else
  assign txn_count = '0;
`endif

endmodule

// File: tb/tb_behav_and_gate.sv
// Self-checking bench for behav_and_gate: a WIDTH=1 and a WIDTH=8/CNT_W=2 instance
// share control inputs and are compared every cycle against a transaction-level model.
module tb_behav_and_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        a1, b1;
  logic [7:0]  a8, b8;

  logic        in_ready1, s1, s_all1, s_any1, out_valid1;
  logic [15:0] txn1;
  logic        in_ready8, s_all8, s_any8, out_valid8;
  logic [7:0]  s8;
  logic [1:0]  txn8;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  always #5 clk = ~clk;

  behav_and_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid), .in_ready(in_ready1),
    .s(s1), .s_all(s_all1), .s_any(s_any1), .out_valid(out_valid1),
    .out_ready(out_ready), .txn_count(txn1)
  );

  behav_and_gate #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid), .in_ready(in_ready8),
    .s(s8), .s_all(s_all8), .s_any(s_any8), .out_valid(out_valid8),
    .out_ready(out_ready), .txn_count(txn8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a result slot of capacity one per instance, plus a count of accepted transactions.
  logic [63:0] q1[$];
  logic [63:0] q8[$];
  logic [63:0] last1 = 0, last8 = 0;
  int          tot1 = 0, tot8 = 0;

  function automatic logic [63:0] exp_cnt(input int total, input int max_val);
`ifdef BEHAV_AND_GATE_STATS_EN
    return (total > max_val) ? 64'(max_val) : 64'(total);
`else
    return 64'(0 * total * max_val);
`endif
  endfunction

  always @(posedge clk) begin
    bit pop1, acc1, pop8, acc8;
    pop1 = (q1.size() != 0) && out_ready;
    acc1 = in_valid && !rst && ((q1.size() == 0) || pop1);
    pop8 = (q8.size() != 0) && out_ready;
    acc8 = in_valid && !rst && ((q8.size() == 0) || pop8);
    if (rst) begin
      q1.delete(); q8.delete();
      last1 = 0; last8 = 0; tot1 = 0; tot8 = 0;
    end else begin
      if (pop1) void'(q1.pop_front());
      if (pop8) void'(q8.pop_front());
      if (acc1) begin last1 = 64'(a1 & b1); q1.push_back(last1); tot1++; end
      if (acc8) begin last8 = 64'(a8 & b8); q8.push_back(last8); tot8++; end
    end
  end

  // Compare every output of both instances mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      check("in_ready1",  64'(in_ready1),  64'(((q1.size() == 0) || out_ready) && !rst));
      check("out_valid1", 64'(out_valid1), 64'(q1.size() != 0));
      check("s1",         64'(s1),         last1);
      check("s_all1",     64'(s_all1),     64'(last1 == 64'h1));
      check("s_any1",     64'(s_any1),     64'(last1 != 0));
      check("txn1",       64'(txn1),       exp_cnt(tot1, 65535));
      check("in_ready8",  64'(in_ready8),  64'(((q8.size() == 0) || out_ready) && !rst));
      check("out_valid8", 64'(out_valid8), 64'(q8.size() != 0));
      check("s8",         64'(s8),         last8);
      check("s_all8",     64'(s_all8),     64'(last8 == 64'hFF));
      check("s_any8",     64'(s_any8),     64'(last8 != 0));
      check("txn8",       64'(txn8),       exp_cnt(tot8, 3));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_ab  [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
  logic       tt_s   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] sat_a  [5] = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
  logic [63:0] sat_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
`ifdef BEHAV_AND_GATE_STATS_EN
    sat_exp = 64'd3;
`else
    sat_exp = 64'd0;
`endif
    cycle(); cycle();
    check("rst out_valid8", 64'(out_valid8), 64'd0);
    check("rst s8",         64'(s8),         64'd0);
    check("rst txn8",       64'(txn8),       64'd0);
    check("rst in_ready8",  64'(in_ready8),  64'd0);
    check("rst s_any8",     64'(s_any8),     64'd0);

    // WIDTH=1 truth table, one operand pair per clock with no backpressure.
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = tt_ab[i];
      cycle();
      check("tt s1",         64'(s1),         64'(tt_s[i]));
      check("tt out_valid1", 64'(out_valid1), 64'd1);
    end

    // WIDTH=8 patterns.
    a8 = 8'hF0; b8 = 8'h3C;
    cycle();
    check("f0&3c s8",     64'(s8),     64'h30);
    check("f0&3c s_all8", 64'(s_all8), 64'd0);
    check("f0&3c s_any8", 64'(s_any8), 64'd1);
    a8 = 8'hFF; b8 = 8'hFF;
    cycle();
    check("ff&ff s8",     64'(s8),     64'hFF);
    check("ff&ff s_all8", 64'(s_all8), 64'd1);

    // Backpressure: result 0x0A held for 3 cycles while new operands are offered.
    a8 = 8'h5A; b8 = 8'h0F;
    cycle();
    check("bp load s8", 64'(s8), 64'h0A);
    out_ready = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    #1;
    check("bp in_ready8", 64'(in_ready8), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp hold s8",        64'(s8),         64'h0A);
      check("bp hold out_valid", 64'(out_valid8), 64'd1);
      check("bp hold in_ready8", 64'(in_ready8),  64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("drain out_valid8", 64'(out_valid8), 64'd0);
    check("drain s8 held",    64'(s8),         64'h0A);

    // Reset while a result is pending and backpressured.
    in_valid = 1'b1; out_ready = 1'b0; a8 = 8'hAA; b8 = 8'hAA;
    cycle();
    check("pre-rst out_valid8", 64'(out_valid8), 64'd1);
    rst = 1'b1;
    cycle();
    check("mid-rst out_valid8", 64'(out_valid8), 64'd0);
    check("mid-rst s8",         64'(s8),         64'd0);
    check("mid-rst txn8",       64'(txn8),       64'd0);
    check("mid-rst s_all8",     64'(s_all8),     64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("post-rst out_valid8", 64'(out_valid8), 64'd0);

    // Counter saturation on the CNT_W=2 instance: five acceptances.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a8 = sat_a[i]; b8 = 8'hFF;
      cycle();
    end
    check("sat txn8", 64'(txn8), sat_exp);
    check("sat s8",   64'(s8),   64'h78);
    in_valid = 1'b0;
    cycle(); cycle();

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
